// File: rtl/dmem_port_arbiter_if.sv
// Request/response and BRAM-side signal bundle for dmem_port_arbiter.
// slave = the arbiter, master = requesters plus the BRAM model.
interface dmem_port_arbiter_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [AWIDTH-1:0] req0_addr;
    logic [3:0]        req0_wea;
    logic [DWIDTH-1:0] req0_wdata;
    logic              resp0_valid;
    logic [DWIDTH-1:0] resp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic [AWIDTH-1:0] req1_addr;
    logic [3:0]        req1_wea;
    logic [DWIDTH-1:0] req1_wdata;
    logic              resp1_valid;
    logic [DWIDTH-1:0] resp1_rdata;

    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [3:0]        mem_wea;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_addr, req0_wea, req0_wdata,
        input  req1_valid, req1_addr, req1_wea, req1_wdata,
        input  mem_rdata,
        output req0_ready, resp0_valid, resp0_rdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output mem_en, mem_addr, mem_wea, mem_wdata
    );

    modport master (
        output req0_valid, req0_addr, req0_wea, req0_wdata,
        output req1_valid, req1_addr, req1_wea, req1_wdata,
        output mem_rdata,
        input  req0_ready, resp0_valid, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  mem_en, mem_addr, mem_wea, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port byte-enabled data BRAM.
// Define DMEM_ARB_STARVE_GUARD_EN to bound port 1 waiting to MAX_WAIT cycles.
module dmem_port_arbiter #(
    parameter int AWIDTH   = 14,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("dmem_port_arbiter: MAX_WAIT must be in 1..255");
        end
    endgenerate

    logic              w_starve;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_read;
    logic              w_mem_en;
    logic [AWIDTH-1:0] w_mem_addr;
    logic [3:0]        w_mem_wea;
    logic [DWIDTH-1:0] w_mem_wdata;
    logic              w_resp0_valid;
    logic              w_resp1_valid;
    logic [DWIDTH-1:0] w_resp0_rdata;
    logic [DWIDTH-1:0] w_resp1_rdata;
    logic              r_rsp_pend;
    logic              r_rsp_sel;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    logic [7:0] r_wait_cnt;

    assign w_starve = (r_wait_cnt == WAIT_LIMIT);

    // Port 1 starvation counter: counts stalled cycles, saturates, clears on grant or idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (!bus.req1_valid || w_acc1) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt != WAIT_LIMIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    // Ready depends only on the valids and the starvation state, never on the other ready.
    assign bus.req0_ready = !(bus.req1_valid && w_starve);
    assign bus.req1_ready = !bus.req0_valid || w_starve;
    assign w_acc0 = bus.req0_valid && bus.req0_ready;
    assign w_acc1 = bus.req1_valid && bus.req1_ready;
    assign w_read = (w_acc0 && (bus.req0_wea == 4'b0000)) ||
                    (w_acc1 && (bus.req1_wea == 4'b0000));

    // Winner's request drives the BRAM with zero added latency; idle bus is all zeros
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_addr  = {AWIDTH{1'b0}};
        w_mem_wea   = 4'b0000;
        w_mem_wdata = {DWIDTH{1'b0}};
        if (w_acc0) begin
            w_mem_en    = 1'b1;
            w_mem_addr  = bus.req0_addr;
            w_mem_wea   = bus.req0_wea;
            w_mem_wdata = bus.req0_wdata;
        end else if (w_acc1) begin
            w_mem_en    = 1'b1;
            w_mem_addr  = bus.req1_addr;
            w_mem_wea   = bus.req1_wea;
            w_mem_wdata = bus.req1_wdata;
        end else begin
            w_mem_en    = 1'b0;
            w_mem_addr  = {AWIDTH{1'b0}};
            w_mem_wea   = 4'b0000;
            w_mem_wdata = {DWIDTH{1'b0}};
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wea   = w_mem_wea;
    assign bus.mem_wdata = w_mem_wdata;

    // Remember whether last cycle's accept was a read and which port owns the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_pend <= 1'b0;
            r_rsp_sel  <= 1'b0;
        end else begin
            r_rsp_pend <= w_read;
            r_rsp_sel  <= w_acc1;
        end
    end

    // Steer BRAM read data to the owning port; rst gating kills a response caught mid-reset
    always_comb begin
        w_resp0_valid = 1'b0;
        w_resp1_valid = 1'b0;
        w_resp0_rdata = {DWIDTH{1'b0}};
        w_resp1_rdata = {DWIDTH{1'b0}};
        if (r_rsp_pend && !rst) begin
            if (r_rsp_sel) begin
                w_resp1_valid = 1'b1;
                w_resp1_rdata = bus.mem_rdata;
            end else begin
                w_resp0_valid = 1'b1;
                w_resp0_rdata = bus.mem_rdata;
            end
        end else begin
            w_resp0_valid = 1'b0;
            w_resp1_valid = 1'b0;
        end
    end

    assign bus.resp0_valid = w_resp0_valid;
    assign bus.resp0_rdata = w_resp0_rdata;
    assign bus.resp1_valid = w_resp1_valid;
    assign bus.resp1_rdata = w_resp1_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed cases then random traffic
// against a transaction-level model (winner rule, shadow memory, one-cycle read latency).
module tb_dmem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dmem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // BRAM model: 256 words, one-cycle read latency, byte write enables
    logic [31:0] bram [0:255];
    always_ff @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wea == 4'b0000) begin
                bus.mem_rdata <= bram[bus.mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wea[b]) bram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          waited;
    bit          exp_pend;
    bit          exp_port;
    logic [31:0] exp_data;
    bit          last_acc0, last_acc1;

    // Observed outputs of the most recent cycle
    logic        obs_en, obs_r0v, obs_r1v, obs_rdy1;
    logic [13:0] obs_addr;
    logic [3:0]  obs_wea;
    logic [31:0] obs_r0d, obs_r1d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wea,
                                          input logic [31:0] data);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wea[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance the model after posedge
    task automatic do_cycle(input bit v0, input logic [13:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                            input bit v1, input logic [13:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        bit acc0, acc1;
        logic [13:0] e_addr;
        logic [3:0]  e_wea;
        logic [31:0] e_data;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_wea = w0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_wea = w1; bus.req1_wdata = d1;
        @(negedge clk);
        acc1 = v1 && (!v0 || (GUARD && waited >= MW));
        acc0 = v0 && !acc1;
        e_addr = acc0 ? a0 : (acc1 ? a1 : 14'h0);
        e_wea  = acc0 ? w0 : (acc1 ? w1 : 4'h0);
        e_data = acc0 ? d0 : (acc1 ? d1 : 32'h0);
        obs_en = bus.mem_en; obs_addr = bus.mem_addr; obs_wea = bus.mem_wea;
        obs_r0v = bus.resp0_valid; obs_r0d = bus.resp0_rdata;
        obs_r1v = bus.resp1_valid; obs_r1d = bus.resp1_rdata;
        obs_rdy1 = bus.req1_ready;
        if (v0) chk("req0_ready", 64'(bus.req0_ready), 64'(acc0));
        if (v1) chk("req1_ready", 64'(bus.req1_ready), 64'(acc1));
        chk("mem_en",    64'(bus.mem_en),    64'(acc0 || acc1));
        chk("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
        chk("mem_wea",   64'(bus.mem_wea),   64'(e_wea));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_data));
        chk("resp0_valid", 64'(bus.resp0_valid), 64'(exp_pend && !exp_port));
        chk("resp0_rdata", 64'(bus.resp0_rdata), 64'((exp_pend && !exp_port) ? exp_data : 32'h0));
        chk("resp1_valid", 64'(bus.resp1_valid), 64'(exp_pend && exp_port));
        chk("resp1_rdata", 64'(bus.resp1_rdata), 64'((exp_pend && exp_port) ? exp_data : 32'h0));
        last_acc0 = acc0;
        last_acc1 = acc1;
        @(posedge clk);
        #1;
        exp_pend = (acc0 && w0 == 4'h0) || (acc1 && w1 == 4'h0);
        exp_port = acc1;
        if (acc0 && w0 == 4'h0) exp_data = ref_mem[a0[7:0]];
        if (acc1 && w1 == 4'h0) exp_data = ref_mem[a1[7:0]];
        if (acc0 && w0 != 4'h0) ref_mem[a0[7:0]] = merge(ref_mem[a0[7:0]], w0, d0);
        if (acc1 && w1 != 4'h0) ref_mem[a1[7:0]] = merge(ref_mem[a1[7:0]], w1, d1);
        waited = (v1 && !acc1) ? ((waited < MW) ? waited + 1 : MW) : 0;
    endtask

    task automatic idle();
        do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 14'h0, 4'h0, 32'h0);
    endtask

    initial begin
        bit          pend0, pend1;
        logic [13:0] ra0, ra1;
        logic [3:0]  rw0, rw1;
        logic [31:0] rd0, rd1, d;

        bus.req0_valid = 1'b0; bus.req0_addr = 14'h0; bus.req0_wea = 4'h0; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_addr = 14'h0; bus.req1_wea = 4'h0; bus.req1_wdata = 32'h0;
        waited = 0; exp_pend = 1'b0; exp_port = 1'b0; exp_data = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", 64'(bus.mem_en), 64'(1'b0));
        chk("rst_mem_wea", 64'(bus.mem_wea), 64'(4'h0));
        chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'(1'b0));
        chk("rst_resp1_valid", 64'(bus.resp1_valid), 64'(1'b0));
        chk("rst_resp0_rdata", 64'(bus.resp0_rdata), 64'(32'h0));
        chk("rst_resp1_rdata", 64'(bus.resp1_rdata), 64'(32'h0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload every word through alternating ports
        for (int i = 0; i < 256; i++) begin
            d = (i == 16) ? 32'hDEADBEEF : $urandom;
            if (i % 2 == 0) do_cycle(1'b1, 14'(i), 4'hF, d, 1'b0, 14'h0, 4'h0, 32'h0);
            else            do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 14'(i), 4'hF, d);
        end

        // Port 0 read of 0x010
        do_cycle(1'b1, 14'h010, 4'h0, 32'h0, 1'b0, 14'h0, 4'h0, 32'h0);
        chk("t1_mem_en", 64'(obs_en), 64'(1'b1));
        chk("t1_mem_addr", 64'(obs_addr), 64'(14'h010));
        chk("t1_mem_wea", 64'(obs_wea), 64'(4'h0));
        chk("t1_resp1_T", 64'(obs_r1v), 64'(1'b0));
        idle();
        chk("t1_resp0_valid", 64'(obs_r0v), 64'(1'b1));
        chk("t1_resp0_rdata", 64'(obs_r0d), 64'(32'hDEADBEEF));
        chk("t1_resp1_T1", 64'(obs_r1v), 64'(1'b0));

        // Simultaneous writes to one word, then readback
        do_cycle(1'b1, 14'h020, 4'hF, 32'h11111111, 1'b1, 14'h020, 4'h4, 32'h00AB0000);
        chk("t2_first_wea", 64'(obs_wea), 64'(4'hF));
        chk("t2_p1_stall", 64'(obs_rdy1), 64'(1'b0));
        do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 14'h020, 4'h4, 32'h00AB0000);
        chk("t2_second_wea", 64'(obs_wea), 64'(4'h4));
        do_cycle(1'b1, 14'h020, 4'h0, 32'h0, 1'b0, 14'h0, 4'h0, 32'h0);
        idle();
        chk("t2_readback", 64'(obs_r0d), 64'(32'h11AB1111));

        // Continuous port 0 traffic with port 1 waiting
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b1, 14'h010, 4'h0, 32'h0, 1'b1, 14'h030, 4'h0, 32'h0);
            chk("t3_req1_ready", 64'(obs_rdy1), 64'(GUARD && ((k % (MW + 1)) == MW)));
        end
        idle();

        // Alternating back-to-back reads
        do_cycle(1'b1, 14'h001, 4'h0, 32'h0, 1'b0, 14'h0, 4'h0, 32'h0);
        do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 14'h002, 4'h0, 32'h0);
        chk("t4_r0_valid", 64'(obs_r0v), 64'(1'b1));
        chk("t4_r0_data", 64'(obs_r0d), 64'(ref_mem[1]));
        do_cycle(1'b1, 14'h003, 4'h0, 32'h0, 1'b0, 14'h0, 4'h0, 32'h0);
        chk("t4_r1_valid", 64'(obs_r1v), 64'(1'b1));
        chk("t4_r1_data", 64'(obs_r1d), 64'(ref_mem[2]));
        idle();
        chk("t4_r0b_valid", 64'(obs_r0v), 64'(1'b1));
        chk("t4_r0b_data", 64'(obs_r0d), 64'(ref_mem[3]));

        // Reset arriving the cycle after a port 1 read, with some port 1 waiting beforehand
        repeat (2) do_cycle(1'b1, 14'h010, 4'h0, 32'h0, 1'b1, 14'h005, 4'h0, 32'h0);
        do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 14'h005, 4'h0, 32'h0);
        repeat (3) do_cycle(1'b1, 14'h010, 4'h0, 32'h0, 1'b1, 14'h006, 4'h0, 32'h0);
        do_cycle(1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 14'h005, 4'h0, 32'h0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5_resp1_valid", 64'(bus.resp1_valid), 64'(1'b0));
        chk("t5_resp1_rdata", 64'(bus.resp1_rdata), 64'(32'h0));
        chk("t5_resp0_valid", 64'(bus.resp0_valid), 64'(1'b0));
        chk("t5_mem_en", 64'(bus.mem_en), 64'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        exp_pend = 1'b0;
        waited = 0;
        idle();
        for (int k = 0; k < MW + 1; k++) begin
            do_cycle(1'b1, 14'h010, 4'h0, 32'h0, 1'b1, 14'h007, 4'h0, 32'h0);
            chk("t5_post_rst_ready", 64'(obs_rdy1), 64'(GUARD && k == MW));
        end
        idle();

        // Random traffic; a request is held until accepted
        pend0 = 1'b0; pend1 = 1'b0;
        ra0 = 14'h0; ra1 = 14'h0; rw0 = 4'h0; rw1 = 4'h0; rd0 = 32'h0; rd1 = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1'b1;
                ra0 = 14'($urandom_range(0, 255));
                rw0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                rd0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                ra1 = 14'($urandom_range(0, 255));
                rw1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                rd1 = $urandom;
            end
            do_cycle(pend0, ra0, rw0, rd0, pend1, ra1, rw1, rd1);
            if (last_acc0) pend0 = 1'b0;
            if (last_acc1) pend1 = 1'b0;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter in front of the single-port, byte-write-enabled data BRAM. It shares the BRAM between the core's load/store unit (port 0) and a secondary master such as the bootloader/DMA (port 1). Each port presents a request that has already been masked and aligned (word address, 4-bit byte enables, shifted write data). The block selects one request per cycle, drives the BRAM, and routes the one-cycle-latency read data back to the port that issued the read.

## Interface
- `AWIDTH`, default 14: word-address width.
- `DWIDTH`, default 32: data width (XLEN).
- `MAX_WAIT`, default 4: starvation limit for port 1, in cycles; legal range 1..255.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_addr` in AWIDTH: port 0 word address.
- `req0_wea` in 4: port 0 byte enables; `4'b0000` means read.
- `req0_wdata` in DWIDTH: port 0 write data, already lane-aligned.
- `resp0_valid` out 1: port 0 read data valid.
- `resp0_rdata` out DWIDTH: port 0 read data.
- `req1_*` / `resp1_*`: same set for port 1.
- `mem_en` out 1: BRAM enable.
- `mem_addr` out AWIDTH: BRAM address.
- `mem_wea` out 4: BRAM byte write enables.
- `mem_wdata` out DWIDTH: BRAM write data.
- `mem_rdata` in DWIDTH: BRAM read data, valid one cycle after `mem_en` with `mem_wea==0`.

## Operation
- A request is accepted on a cycle where `reqN_valid && reqN_ready`. At most one port is accepted per cycle.
- Priority:
  - Port 0 wins by default.
  - Port 1 wins when only port 1 is valid.
  - Port 1 also wins when `wait_cnt == MAX_WAIT` (guard enabled only).
- `reqN_ready` is combinational from both valids and `wait_cnt`. It never depends on `ready` of either port. A `ready` without a matching `valid` is permitted but has no effect.
- Accepted request: `mem_en=1`, and `mem_addr`/`mem_wea`/`mem_wdata` are copied combinationally from the winner. The byte enables are passed through unchanged (e.g. `4'b0110` for a halfword at byte offset 1).
- No accept: `mem_en=0`, `mem_wea=0`, `mem_addr=0`, `mem_wdata=0`.
- Read accept (`wea==0`):
  - Registers `rsp_pend=1` and `rsp_sel`, the winning port.
  - Next cycle, `resp<rsp_sel>_valid=1` and `resp<rsp_sel>_rdata=mem_rdata`, passed through combinationally.
  - The other port sees `valid=0` and `rdata=0`.
- Write accept: no response. The write is complete at the next rising edge.
- Responses have no back-pressure; requesters must sink them.
- Back-to-back reads, including alternating ports, are sustained at one per cycle. `rsp_sel`/`rsp_pend` are overwritten every cycle.
- Port 1 starvation counter `wait_cnt` (8 bits):
  - +1 each cycle `req1_valid && !req1_ready`, saturating at `MAX_WAIT`.
  - Cleared on a port 1 accept or on `!req1_valid`.
  - Present and functional only with the guard compiled in.

## Timing
- Reset values: `rsp_pend=0`, `rsp_sel=0`, `wait_cnt=0`. Therefore `resp0_valid=resp1_valid=0` and both `rdata=0`. With both valids low, `mem_en=0` and `mem_wea=0`.
- Read latency: accept in cycle T, response in cycle T+1, exactly.
- Request-to-memory path is combinational; there is zero added latency.
- Simultaneous valid requests: one accept per cycle. The loser must hold its request stable until accepted.
- Reset mid-operation: a read accepted in the cycle before `rst` rises produces no response. Responses are suppressed while `rst` is high.
- Counter wrap: none; the counter saturates at `MAX_WAIT`. When the counter is at `MAX_WAIT` and port 1 is granted, it clears on that edge.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN`
  - Defined: the starvation counter is implemented. Port 1 is guaranteed an accept no later than `MAX_WAIT+1` cycles after it starts waiting, even under continuous port 0 traffic.
  - Undefined: strict fixed priority, port 0 always wins. The counter and the `MAX_WAIT` logic are removed; the parameter is ignored.

## Test plan
- Port 0 read at `0x010`, BRAM holds `0xDEADBEEF` -> `mem_en=1`, `mem_wea=0`, `mem_addr=0x010` in T; `resp0_valid=1`, `resp0_rdata=0xDEADBEEF` in T+1; `resp1_valid=0` throughout.
- Both ports write in the same cycle (port 0 `wea=4'b1111` data `0x11111111`, port 1 `wea=4'b0100` data `0x00AB0000`) -> port 0 accepted first, port 1 next cycle with `mem_wea=4'b0100`. A readback returns `0x11AB1111` when both target the same word.
- Guard enabled, `MAX_WAIT=4`, port 0 valid every cycle, port 1 valid from T -> `req1_ready=0` for T..T+3, `req1_ready=1` at T+4, `wait_cnt=0` at T+5.
- Guard disabled, same stimulus for 20 cycles -> `req1_ready` stays 0 for all 20 cycles.
- Alternating reads: port 0 at `0x1`, port 1 at `0x2`, port 0 at `0x3` on consecutive cycles -> responses on port 0, port 1, port 0 in consecutive cycles with matching data.
- Port 1 read accepted in T, `rst` asserted in T+1 -> `resp1_valid=0` in T+1, and all state returns to reset values.
